// File: rtl/hand_cricket_pkg.sv
// Shared types and constants for the hand-cricket match controller.
// Imported by the ball evaluator and the match-level FSM.
package hand_cricket_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INN1  = 3'd1,
    BREAK = 3'd2,
    INN2  = 3'd3,
    DONE  = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    P1   = 2'd1,
    P2   = 2'd2,
    TIE  = 2'd3
  } winner_e;

  localparam logic [2:0] MAX_RUN = 3'd6;

endpackage

// File: rtl/hand_cricket_ball_eval.sv
// Per-ball evaluation: legality, wicket detection and the batter's runs.
// Purely combinational; the match controller registers the results.
import hand_cricket_pkg::*;

module hand_cricket_ball_eval (
  input  logic [2:0] p1_run,
  input  logic [2:0] p2_run,
  input  logic       p1_batting,
  output logic       legal,
  output logic       is_out,
  output logic [2:0] runs
);

  always_comb begin
    legal  = (p1_run <= MAX_RUN) && (p2_run <= MAX_RUN);
    is_out = legal && (p1_run == p2_run);
    runs   = 3'd0;
    if (legal && !is_out)
      runs = p1_batting ? p1_run : p2_run;
  end

endmodule

// File: rtl/hand_cricket_match_ctrl.sv
// Match-level FSM for hand cricket: two innings, role swap at the break,
// chase tracking with early finish, and winner declaration.
import hand_cricket_pkg::*;

module hand_cricket_match_ctrl #(
  parameter int BALLS_PER_INN = 6,
  parameter int WKTS_PER_INN  = 2,
  parameter int SCORE_W       = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               p1_bats_first,
  input  logic               ball_valid,
  input  logic [2:0]         p1_run,
  input  logic [2:0]         p2_run,
  output state_e             state,
  output logic               p1_batting,
  output logic [SCORE_W-1:0] score_p1,
  output logic [SCORE_W-1:0] score_p2,
  output logic [5:0]         ball_cnt,
  output logic [2:0]         wkt_cnt,
  output logic               out_pulse,
  output logic               bad_ball,
  output logic               match_done,
  output logic [1:0]         winner
);

  logic               legal;
  logic               is_out;
  logic [2:0]         runs;
  logic [SCORE_W-1:0] bat_score;
  logic [SCORE_W-1:0] fld_score;
  logic [SCORE_W-1:0] bat_next;
  logic [SCORE_W:0]   sum;
  logic [5:0]         ball_next;
  logic [2:0]         wkt_next;
  logic               inn_end;
  logic               chased;

  hand_cricket_ball_eval u_eval (
    .p1_run     (p1_run),
    .p2_run     (p2_run),
    .p1_batting (p1_batting),
    .legal      (legal),
    .is_out     (is_out),
    .runs       (runs)
  );

  // In INN2 the fielding side's score is the target set in INN1.
  always_comb begin
    bat_score = p1_batting ? score_p1 : score_p2;
    fld_score = p1_batting ? score_p2 : score_p1;
    sum       = {1'b0, bat_score} + (SCORE_W+1)'(runs);
    bat_next  = sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
    ball_next = ball_cnt + 6'd1;
    wkt_next  = wkt_cnt + {2'b00, is_out};
    inn_end   = (wkt_next == 3'(WKTS_PER_INN)) ||
                (ball_next == 6'(BALLS_PER_INN));
    chased    = bat_next > fld_score;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      p1_batting <= 1'b0;
      score_p1   <= '0;
      score_p2   <= '0;
      ball_cnt   <= '0;
      wkt_cnt    <= '0;
      out_pulse  <= 1'b0;
      bad_ball   <= 1'b0;
      match_done <= 1'b0;
      winner     <= NONE;
    end else begin
      out_pulse <= 1'b0;
      bad_ball  <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= INN1;
            p1_batting <= p1_bats_first;
            score_p1   <= '0;
            score_p2   <= '0;
            ball_cnt   <= '0;
            wkt_cnt    <= '0;
            match_done <= 1'b0;
            winner     <= NONE;
          end
        end
        INN1, INN2: begin
          if (ball_valid && !legal) begin
            bad_ball <= 1'b1;
          end else if (ball_valid) begin
            ball_cnt  <= ball_next;
            wkt_cnt   <= wkt_next;
            out_pulse <= is_out;
            if (p1_batting) score_p1 <= bat_next;
            else            score_p2 <= bat_next;
            if (state == INN1) begin
              if (inn_end) state <= BREAK;
            end else if (chased) begin
              state      <= DONE;
              match_done <= 1'b1;
              winner     <= p1_batting ? P1 : P2;
            end else if (inn_end) begin
              state      <= DONE;
              match_done <= 1'b1;
              if (bat_next == fld_score) winner <= TIE;
              else winner <= p1_batting ? P2 : P1;
            end
          end
        end
        BREAK: begin
          state      <= INN2;
          ball_cnt   <= '0;
          wkt_cnt    <= '0;
          p1_batting <= ~p1_batting;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hand_cricket_match_ctrl.sv
// Bench for hand_cricket_match_ctrl: vector table through a scoreboard
// queue, plus saturation and asynchronous-reset corner cases.
import hand_cricket_pkg::*;

module tb_hand_cricket_match_ctrl;

  typedef struct packed {
    logic [2:0] st;
    logic       bat;
    logic [7:0] s1;
    logic [7:0] s2;
    logic [5:0] b;
    logic [2:0] w;
    logic       o;
    logic       x;
    logic       d;
    logic [1:0] win;
  } out_t;

  typedef struct {
    logic       rs;
    logic       st;
    logic       tf;
    logic       bv;
    logic [2:0] r1;
    logic [2:0] r2;
    out_t       e;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       p1_bats_first = 1'b0;
  logic       ball_valid = 1'b0;
  logic [2:0] p1_run = 3'd0;
  logic [2:0] p2_run = 3'd0;

  state_e     state;
  logic       p1_batting;
  logic [7:0] score_p1, score_p2;
  logic [5:0] ball_cnt;
  logic [2:0] wkt_cnt;
  logic       out_pulse, bad_ball, match_done;
  logic [1:0] winner;

  state_e     state_b;
  logic       p1_batting_b;
  logic [3:0] score_p1_b, score_p2_b;
  logic [5:0] ball_cnt_b;
  logic [2:0] wkt_cnt_b;
  logic       out_pulse_b, bad_ball_b, match_done_b;
  logic [1:0] winner_b;

  int npass = 0;
  int ntot  = 0;
  out_t exp_q[$];
  vec_t vecs[$];
  int   sat_idx;

  always #5 clk = ~clk;

  hand_cricket_match_ctrl dut (
    .clk(clk), .reset(reset), .start(start),
    .p1_bats_first(p1_bats_first), .ball_valid(ball_valid),
    .p1_run(p1_run), .p2_run(p2_run), .state(state),
    .p1_batting(p1_batting), .score_p1(score_p1), .score_p2(score_p2),
    .ball_cnt(ball_cnt), .wkt_cnt(wkt_cnt), .out_pulse(out_pulse),
    .bad_ball(bad_ball), .match_done(match_done), .winner(winner)
  );

  hand_cricket_match_ctrl #(.SCORE_W(4)) dut4 (
    .clk(clk), .reset(reset), .start(start),
    .p1_bats_first(p1_bats_first), .ball_valid(ball_valid),
    .p1_run(p1_run), .p2_run(p2_run), .state(state_b),
    .p1_batting(p1_batting_b), .score_p1(score_p1_b),
    .score_p2(score_p2_b), .ball_cnt(ball_cnt_b), .wkt_cnt(wkt_cnt_b),
    .out_pulse(out_pulse_b), .bad_ball(bad_ball_b),
    .match_done(match_done_b), .winner(winner_b)
  );

  function automatic out_t E(state_e s, bit bat, int s1, int s2,
                             int b, int w, bit o, bit x, bit d, int win);
    out_t r;
    r.st = s; r.bat = bat; r.s1 = 8'(s1); r.s2 = 8'(s2);
    r.b = 6'(b); r.w = 3'(w); r.o = o; r.x = x; r.d = d;
    r.win = 2'(win);
    return r;
  endfunction

  function automatic vec_t V(bit rs, bit st, bit tf, bit bv,
                             int r1, int r2, out_t e);
    vec_t v;
    v.rs = rs; v.st = st; v.tf = tf; v.bv = bv;
    v.r1 = 3'(r1); v.r2 = 3'(r2); v.e = e;
    return v;
  endfunction

  function automatic out_t sample();
    out_t r;
    r.st = state; r.bat = p1_batting; r.s1 = score_p1; r.s2 = score_p2;
    r.b = ball_cnt; r.w = wkt_cnt; r.o = out_pulse; r.x = bad_ball;
    r.d = match_done; r.win = winner;
    return r;
  endfunction

  task automatic check(string name, out_t a, out_t e);
    ntot++;
    if (a === e) npass++;
    else $display("FAIL %s: got st=%0d bat=%0d s1=%0d s2=%0d b=%0d w=%0d o=%0d x=%0d d=%0d win=%0d | want st=%0d bat=%0d s1=%0d s2=%0d b=%0d w=%0d o=%0d x=%0d d=%0d win=%0d",
      name, a.st, a.bat, a.s1, a.s2, a.b, a.w, a.o, a.x, a.d, a.win,
      e.st, e.bat, e.s1, e.s2, e.b, e.w, e.o, e.x, e.d, e.win);
  endtask

  task automatic step(string name, vec_t v);
    out_t e;
    @(negedge clk);
    reset = v.rs; start = v.st; p1_bats_first = v.tf;
    ball_valid = v.bv; p1_run = v.r1; p2_run = v.r2;
    exp_q.push_back(v.e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check(name, sample(), e);
  endtask

  // Shorthand pushers keep the table readable.
  function automatic void RS();
    vecs.push_back(V(1, 0, 0, 0, 0, 0, E(IDLE, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
  endfunction
  function automatic void ST(bit tf, out_t e);
    vecs.push_back(V(0, 1, tf, 0, 0, 0, e));
  endfunction
  function automatic void BL(int r1, int r2, out_t e);
    vecs.push_back(V(0, 0, 0, 1, r1, r2, e));
  endfunction
  function automatic void NO(out_t e);
    vecs.push_back(V(0, 0, 0, 0, 0, 0, e));
  endfunction

  initial begin
    // Full six-ball innings, stray strobes in BREAK/DONE, all-out chase.
    RS();
    ST(1, E(INN1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    BL(3, 0, E(INN1, 1, 3, 0, 1, 0, 0, 0, 0, 0));
    BL(4, 0, E(INN1, 1, 7, 0, 2, 0, 0, 0, 0, 0));
    BL(5, 0, E(INN1, 1, 12, 0, 3, 0, 0, 0, 0, 0));
    BL(1, 0, E(INN1, 1, 13, 0, 4, 0, 0, 0, 0, 0));
    BL(2, 0, E(INN1, 1, 15, 0, 5, 0, 0, 0, 0, 0));
    BL(6, 0, E(BREAK, 1, 21, 0, 6, 0, 0, 0, 0, 0));
    BL(7, 0, E(INN2, 0, 21, 0, 0, 0, 0, 0, 0, 0));
    ST(1, E(INN2, 0, 21, 0, 0, 0, 0, 0, 0, 0));
    BL(2, 2, E(INN2, 0, 21, 0, 1, 1, 1, 0, 0, 0));
    BL(5, 5, E(DONE, 0, 21, 0, 2, 2, 1, 0, 1, 1));
    NO(E(DONE, 0, 21, 0, 2, 2, 0, 0, 1, 1));
    BL(3, 0, E(DONE, 0, 21, 0, 2, 2, 0, 0, 1, 1));
    // Two wickets end INN1; a single run wins the chase.
    ST(1, E(INN1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    BL(3, 3, E(INN1, 1, 0, 0, 1, 1, 1, 0, 0, 0));
    BL(4, 4, E(BREAK, 1, 0, 0, 2, 2, 1, 0, 0, 0));
    NO(E(INN2, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    BL(0, 1, E(DONE, 0, 0, 1, 1, 0, 0, 0, 1, 2));
    // Level at 10 is not a win; the next run is. Bad ball and start ignored.
    ST(1, E(INN1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    BL(6, 0, E(INN1, 1, 6, 0, 1, 0, 0, 0, 0, 0));
    BL(4, 0, E(INN1, 1, 10, 0, 2, 0, 0, 0, 0, 0));
    BL(1, 1, E(INN1, 1, 10, 0, 3, 1, 1, 0, 0, 0));
    BL(7, 2, E(INN1, 1, 10, 0, 3, 1, 0, 1, 0, 0));
    ST(0, E(INN1, 1, 10, 0, 3, 1, 0, 0, 0, 0));
    BL(0, 0, E(BREAK, 1, 10, 0, 4, 2, 1, 0, 0, 0));
    NO(E(INN2, 0, 10, 0, 0, 0, 0, 0, 0, 0));
    BL(0, 6, E(INN2, 0, 10, 6, 1, 0, 0, 0, 0, 0));
    BL(0, 4, E(INN2, 0, 10, 10, 2, 0, 0, 0, 0, 0));
    BL(0, 1, E(DONE, 0, 10, 11, 3, 0, 0, 0, 1, 2));
    // Chaser all out level at 10: tie.
    ST(1, E(INN1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    BL(6, 0, E(INN1, 1, 6, 0, 1, 0, 0, 0, 0, 0));
    BL(4, 0, E(INN1, 1, 10, 0, 2, 0, 0, 0, 0, 0));
    BL(2, 2, E(INN1, 1, 10, 0, 3, 1, 1, 0, 0, 0));
    BL(3, 3, E(BREAK, 1, 10, 0, 4, 2, 1, 0, 0, 0));
    NO(E(INN2, 0, 10, 0, 0, 0, 0, 0, 0, 0));
    BL(0, 6, E(INN2, 0, 10, 6, 1, 0, 0, 0, 0, 0));
    BL(0, 4, E(INN2, 0, 10, 10, 2, 0, 0, 0, 0, 0));
    BL(1, 1, E(INN2, 0, 10, 10, 3, 1, 1, 0, 0, 0));
    BL(2, 2, E(DONE, 0, 10, 10, 4, 2, 1, 0, 1, 3));
    // P2 bats first; P1 runs out of balls short of the target.
    ST(0, E(INN1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    BL(0, 5, E(INN1, 0, 0, 5, 1, 0, 0, 0, 0, 0));
    BL(1, 1, E(INN1, 0, 0, 5, 2, 1, 1, 0, 0, 0));
    BL(2, 2, E(BREAK, 0, 0, 5, 3, 2, 1, 0, 0, 0));
    NO(E(INN2, 1, 0, 5, 0, 0, 0, 0, 0, 0));
    BL(1, 0, E(INN2, 1, 1, 5, 1, 0, 0, 0, 0, 0));
    BL(1, 0, E(INN2, 1, 2, 5, 2, 0, 0, 0, 0, 0));
    BL(1, 0, E(INN2, 1, 3, 5, 3, 0, 0, 0, 0, 0));
    BL(1, 0, E(INN2, 1, 4, 5, 4, 0, 0, 0, 0, 0));
    BL(0, 1, E(INN2, 1, 4, 5, 5, 0, 0, 0, 0, 0));
    BL(0, 2, E(DONE, 1, 4, 5, 6, 0, 0, 0, 1, 2));
    // 6,6,6: 18 on the 8-bit instance, 15 on the 4-bit one.
    RS();
    ST(1, E(INN1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    BL(6, 0, E(INN1, 1, 6, 0, 1, 0, 0, 0, 0, 0));
    BL(6, 0, E(INN1, 1, 12, 0, 2, 0, 0, 0, 0, 0));
    BL(6, 0, E(INN1, 1, 18, 0, 3, 0, 0, 0, 0, 0));
    sat_idx = vecs.size() - 1;
    // Reach INN2 with P1 on 12 for the asynchronous reset.
    RS();
    ST(0, E(INN1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    BL(0, 6, E(INN1, 0, 0, 6, 1, 0, 0, 0, 0, 0));
    BL(0, 6, E(INN1, 0, 0, 12, 2, 0, 0, 0, 0, 0));
    BL(0, 6, E(INN1, 0, 0, 18, 3, 0, 0, 0, 0, 0));
    BL(1, 1, E(INN1, 0, 0, 18, 4, 1, 1, 0, 0, 0));
    BL(2, 2, E(BREAK, 0, 0, 18, 5, 2, 1, 0, 0, 0));
    NO(E(INN2, 1, 0, 18, 0, 0, 0, 0, 0, 0));
    BL(6, 0, E(INN2, 1, 6, 18, 1, 0, 0, 0, 0, 0));
    BL(6, 0, E(INN2, 1, 12, 18, 2, 0, 0, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      step($sformatf("vec%0d", i), vecs[i]);
      if (i == sat_idx) begin
        ntot++;
        if (score_p1_b === 4'd15) npass++;
        else $display("FAIL sat4: got score_p1=%0d want 15", score_p1_b);
      end
    end

    // Reset between clock edges must clear everything at once.
    @(negedge clk);
    start = 1'b0; ball_valid = 1'b0;
    #2 reset = 1'b1;
    #1 check("async_reset", sample(),
             E(IDLE, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step("fresh_start", V(0, 1, 1, 0, 0, 0,
         E(INN1, 1, 0, 0, 0, 0, 0, 0, 0, 0)));
    step("fresh_ball", V(0, 0, 0, 1, 2, 0,
         E(INN1, 1, 2, 0, 1, 0, 0, 0, 0, 0)));

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/hand_cricket_match_ctrl.md
# hand_cricket_match_ctrl

Match-level controller for the hand-cricket game. It sequences two innings over the per-ball scoring datapath. Each innings gets a configurable ball budget and wicket budget; the controller swaps batting and bowling roles at the break, tracks the chase target and declares the winner. It sits between the board's input/edge-detect logic (which supplies one-cycle `start` and `ball_valid` strobes) and the LED/score display.

## Interface
- `BALLS_PER_INN`, default 6: legal balls per innings (1..63).
- `WKTS_PER_INN`, default 2: wickets that end an innings (1..7).
- `SCORE_W`, default 8: width of each score register.

- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high.
- `start`  in  1  one-cycle strobe; begins a match from IDLE or DONE.
- `p1_bats_first`  in  1  toss result; sampled only on an accepted `start`.
- `ball_valid`  in  1  one-cycle strobe; `p1_run` and `p2_run` are valid this cycle.
- `p1_run`  in  3  player 1 throw, legal values 0..6.
- `p2_run`  in  3  player 2 throw, legal values 0..6.
- `state`  out  3  current FSM state (package enum).
- `p1_batting`  out  1  1 when player 1 is the current batter.
- `score_p1`  out  SCORE_W  player 1 total.
- `score_p2`  out  SCORE_W  player 2 total.
- `ball_cnt`  out  6  legal balls bowled in the current innings.
- `wkt_cnt`  out  3  wickets lost in the current innings.
- `out_pulse`  out  1  one-cycle pulse when a wicket falls.
- `bad_ball`  out  1  one-cycle pulse when a ball is rejected.
- `match_done`  out  1  high while in DONE.
- `winner`  out  2  00 none, 01 P1, 10 P2, 11 tie.

## Operation
- States:
  - IDLE: after reset; waits for `start`.
  - INN1: first innings.
  - BREAK: exactly one cycle between innings.
  - INN2: second innings (the chase).
  - DONE: result held.
- IDLE/DONE → INN1 on `start`. This clears both scores, `ball_cnt`, `wkt_cnt` and `winner`, and sets `p1_batting` = `p1_bats_first`.
- `start` is ignored in INN1, BREAK and INN2.
- Ball acceptance: only in INN1/INN2 with `ball_valid`=1.
  - Reject if either run is 7: pulse `bad_ball`, change no counters.
- Accepted ball evaluation:
  - `ball_cnt` += 1.
  - If `p1_run` == `p2_run`: `wkt_cnt` += 1, pulse `out_pulse`, no runs scored.
  - Otherwise: the batter's score += the batter's own run value. The addition saturates at 2^SCORE_W−1.
- Innings end, evaluated on the updated counters: `wkt_cnt` == WKTS_PER_INN or `ball_cnt` == BALLS_PER_INN.
  - In INN1, innings end → BREAK.
- BREAK:
  - Clear `ball_cnt` and `wkt_cnt`.
  - Toggle `p1_batting`.
  - Go to INN2. `ball_valid` is ignored in this state.
- Early finish in INN2: if the chaser's updated score exceeds the first-innings score, go to DONE immediately, regardless of balls remaining.
- In INN2, innings end without a successful chase → DONE.
- Winner, set on entry to DONE:
  - Chaser ahead → chaser wins.
  - Scores equal → 11 (tie).
  - Otherwise → first batter wins.
- DONE holds all scores and `winner` until `start` or `reset`.

## Timing
- Reset values: `state` = IDLE; `p1_batting` = 0; scores, `ball_cnt`, `wkt_cnt` = 0; `out_pulse` = `bad_ball` = `match_done` = 0; `winner` = 00.
- All outputs are registered. A ball presented at edge N is reflected at edge N: counters, scores, pulses and any state change all appear together, so they are visible in cycle N+1.
- `out_pulse` and `bad_ball` are high for exactly one cycle.
- Innings-ending ball: the final counter values are visible for the single BREAK cycle. They read as 0 in the first INN2 cycle.
- A `ball_valid` in the same cycle the FSM enters BREAK or DONE is impossible by construction. Any strobe arriving while in BREAK or DONE is dropped silently, with no `bad_ball`.
- Asynchronous `reset` mid-innings returns everything to reset values immediately. No partial match survives.
- Back-to-back `ball_valid` on every cycle is legal and each strobe is processed.

## Structure
- `hand_cricket_pkg` holds:
  - `state_e` enum: IDLE, INN1, BREAK, INN2, DONE.
  - `winner_e` enum: NONE, P1, P2, TIE.
  - `MAX_RUN` = 6.
- One combinational sub-module, `hand_cricket_ball_eval`. It takes both runs and the batter select, and produces `legal`, `is_out` and `runs`.
- The FSM, counters and saturating adders live in the top module.

## Test plan
- Reset, `start` with `p1_bats_first`=1; P1 scores 3,4,5,1,2,6 (P2 never matches) → after ball 6, state BREAK, `score_p1` = 21, `ball_cnt` = 6, then INN2 with `p1_batting` = 0.
- INN1: two matching throws on balls 1–2 → two `out_pulse`s, innings ends at `ball_cnt` = 2. INN2: P2 scores 1 → DONE after 1 ball, `winner` = 10.
- Chase: P1 makes 10. P2 hits 6,4 → not DONE (10 = 10). Next ball 1 → DONE, `score_p2` = 11, `winner` = 10. Separate run with P2 out at 10 → `winner` = 11.
- `p1_run` = 7 on a strobe → `bad_ball` pulses, `ball_cnt` unchanged. `ball_valid` during BREAK → ignored. `start` during INN1 → ignored.
- SCORE_W = 4: P1 accumulates 6,6,6 → `score_p1` saturates at 15.
- Assert `reset` mid-INN2 with `score_p1` = 12 → all outputs return to reset values in the same cycle, and the following `start` begins a fresh INN1.
